stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Control and timebase block for the VGA stopwatch. It holds one enable-based prescaler that derives a centisecond tick from the board clock and sequences that prescaler with a start/stop/lap/clear state machine. It also keeps the BCD time count (mm:ss.cc) and a frozen lap copy, and presents the displayed digits to the VGA renderer. All logic stays in the boardCLK domain: the tick is an enable, not a derived clock.

Parameters:
CLK_HZ, 50000000, board clock frequency in Hz
TICK_HZ, 100, tick rate in Hz (centiseconds); DIV = CLK_HZ/TICK_HZ, which must be >= 2 and a whole number

Ports:
boardCLK  in  1  board clock, the only clock
reset  in  1  synchronous, active-high reset
btn_startstop  in  1  one-cycle pulse, already debounced and synchronised
btn_lap  in  1  one-cycle pulse, already debounced and synchronised
btn_clear  in  1  one-cycle pulse, already debounced and synchronised
tick_cs  out  1  one-cycle centisecond tick enable
running  out  1  1 in RUN and LAP
lap_frozen  out  1  1 in LAP
overflow  out  1  one-cycle pulse on the 59:59.99 -> 00:00.00 wrap
min_t  out  3  displayed minutes tens, 0..5
min_o  out  4  displayed minutes ones, 0..9
sec_t  out  3  displayed seconds tens, 0..5
sec_o  out  4  displayed seconds ones, 0..9
cs_t  out  4  displayed centiseconds tens, 0..9
cs_o  out  4  displayed centiseconds ones, 0..9

Behaviour:
- Decided: one clock, boardCLK. Reset is synchronous and active-high, and the name is reset.
- Reset outcome: state IDLE; prescaler, live time and lap registers all 0; tick_cs, running, lap_frozen and overflow all 0; all digits 0.
- Reset priority: reset wins over every input in the same cycle, including mid-run and mid-tick.
- Prescaler count:
  - 32-bit count, advances only in RUN and LAP.
  - When count == DIV-1: tick_cs = 1 on that cycle (registered output, asserted the cycle after the count reaches DIV-1) and count returns to 0. Implementer fixes one of these two timings and documents it; the bench checks tick period = DIV cycles.
- Prescaler on pause: count holds its value, so resuming continues the partial period. Clear zeroes it.
- Live time:
  - BCD cascade cs 00..99, s 00..59, m 00..59; increments on each tick_cs.
  - Each digit carries into the next at its maximum.
  - At 59:59.99 a tick wraps to 00:00.00, overflow pulses for 1 cycle, and the count continues.
- State machine, input priority per cycle: startstop > clear > lap. Only the highest-priority pending input is acted on; the others are dropped.
  - IDLE: startstop -> RUN. clear and lap are ignored.
  - RUN: startstop -> PAUSE. lap -> LAP, capturing the live time registers' current value (the value visible in that cycle) into the lap registers. clear is ignored.
  - LAP: lap -> RUN (display returns to live). startstop -> PAUSE (freeze released). clear is ignored. Live time keeps counting.
  - PAUSE: startstop -> RUN. clear -> IDLE, zeroing live time, lap registers and prescaler. lap is ignored.
- Status outputs: running and lap_frozen are registered decodes of the state and change on the same edge as the state.
- Display digits: a combinational mux, lap_frozen ? lap registers : live registers. No extra latency beyond the register update.
- Tick and startstop on the same cycle in RUN: the tick is counted, then the state moves to PAUSE.
- Tick on the capture cycle in RUN: the lap captures the pre-increment value.
- Digit legality: every digit must always be a legal BCD value within its range; no intermediate illegal digits.

Decomposition:
- Shared package sw_pkg holds:
  - state encoding: IDLE = 2'd0, RUN = 2'd1, LAP = 2'd2, PAUSE = 2'd3
  - digit width constants
  - the DIV calculation with a range check on the parameters
- One sub-module, sw_timebase: enable-gated prescaler with inputs boardCLK, reset, en, clr and output tick. stopwatch_ctrl instantiates it once.
- The BCD cascade and lap registers stay in stopwatch_ctrl.

Test Plan (CLK_HZ=1000, TICK_HZ=100, so DIV=10):
1. Reset, then startstop pulse, then run 1000 cycles -> 100 tick_cs pulses exactly 10 cycles apart; display 00:01.00; running = 1.
2. Run to 00:00.37, startstop, idle 500 cycles, startstop -> display holds 00:00.37 during the pause. The first tick after resume arrives after the remainder of the interrupted period, not a full 10 cycles.
3. Lap at 00:00.25, run 200 more cycles, lap -> lap_frozen = 1 showing 00:00.25 while the live count advances; the second lap shows the live value 00:00.45; lap_frozen = 0.
4. Preload or run to 59:59.99, one tick -> 00:00.00; overflow high for exactly 1 cycle; still running.
5. Same-cycle startstop + lap in RUN -> PAUSE, no lap capture. clear while RUN -> ignored. clear while PAUSE -> IDLE with all digits 0.
6. Assert reset for 1 cycle mid-run, coincident with a tick and btn_lap -> next cycle IDLE, all outputs 0, no tick_cs or overflow pulse.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared types and helpers for the stopwatch: state encoding, BCD time record,
// digit widths, prescaler ratio calculation and the BCD increment.
package sw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_SS,
    SEL_CLR,
    SEL_LAP
  } btn_sel_t;

  localparam int TENS6_W = 3;  // tens digit that only reaches 5
  localparam int DIGIT_W = 4;

  typedef struct packed {
    logic [TENS6_W-1:0] m_t;
    logic [DIGIT_W-1:0] m_o;
    logic [TENS6_W-1:0] s_t;
    logic [DIGIT_W-1:0] s_o;
    logic [DIGIT_W-1:0] c_t;
    logic [DIGIT_W-1:0] c_o;
  } bcd_time_t;

  localparam bcd_time_t TIME_MAX = '{m_t: 3'd5, m_o: 4'd9, s_t: 3'd5,
                                     s_o: 4'd9, c_t: 4'd9, c_o: 4'd9};

  function automatic bit div_ok(input int clk_hz, input int tick_hz);
    if (tick_hz <= 0) return 1'b0;
    return (clk_hz % tick_hz == 0) && (clk_hz / tick_hz >= 2);
  endfunction

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return div_ok(clk_hz, tick_hz) ? clk_hz / tick_hz : 2;
  endfunction

  // Ripple carry through the digits; 59:59.99 wraps to 00:00.00.
  function automatic bcd_time_t bcd_inc(input bcd_time_t t);
    bcd_time_t n;
    n = t;
    if (t.c_o != 4'd9) n.c_o = t.c_o + 4'd1;
    else begin
      n.c_o = '0;
      if (t.c_t != 4'd9) n.c_t = t.c_t + 4'd1;
      else begin
        n.c_t = '0;
        if (t.s_o != 4'd9) n.s_o = t.s_o + 4'd1;
        else begin
          n.s_o = '0;
          if (t.s_t != 3'd5) n.s_t = t.s_t + 3'd1;
          else begin
            n.s_t = '0;
            if (t.m_o != 4'd9) n.m_o = t.m_o + 4'd1;
            else begin
              n.m_o = '0;
              n.m_t = (t.m_t != 3'd5) ? t.m_t + 3'd1 : 3'd0;
            end
          end
        end
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/sw_timebase.sv
// Enable-gated prescaler: tick is registered, high the cycle after the count
// reaches DIV-1, so ticks are DIV enabled cycles apart; no backpressure.
module sw_timebase #(
  parameter int DIV = 10
) (
  input  logic boardCLK,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [31:0] LAST = 32'(DIV - 1);

  logic [31:0] cnt;

  // Count holds while disabled so a resumed run finishes the partial period.
  always_ff @(posedge boardCLK) begin
    if (reset || clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (en) begin
        if (cnt == LAST) begin
          cnt  <= '0;
          tick <= 1'b1;
        end else begin
          cnt <= cnt + 32'd1;
        end
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: start/stop/lap/clear FSM, centisecond BCD count and lap copy.
// State and status update on the button edge; digits are a mux of registers; no backpressure.
module stopwatch_ctrl
  import sw_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 100
) (
  input  logic       boardCLK,
  input  logic       reset,
  input  logic       btn_startstop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic       tick_cs,
  output logic       running,
  output logic       lap_frozen,
  output logic       overflow,
  output logic [2:0] min_t,
  output logic [3:0] min_o,
  output logic [2:0] sec_t,
  output logic [3:0] sec_o,
  output logic [3:0] cs_t,
  output logic [3:0] cs_o
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);

  if (!div_ok(CLK_HZ, TICK_HZ)) begin : g_bad_div
    $error("stopwatch_ctrl: CLK_HZ/TICK_HZ must be a whole number >= 2");
  end

  state_t    state_q, state_nxt;
  btn_sel_t  sel;
  logic      running_nxt, lap_nxt;
  logic      capture, clr;
  bcd_time_t live_q, lap_q, shown;

  sw_timebase #(.DIV(DIV)) u_timebase (
    .boardCLK (boardCLK),
    .reset    (reset),
    .en       (running),
    .clr      (clr),
    .tick     (tick_cs)
  );

  always_ff @(posedge boardCLK) begin
    if (reset) begin
      state_q    <= IDLE;
      running    <= 1'b0;
      lap_frozen <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      running    <= running_nxt;
      lap_frozen <= lap_nxt;
    end
  end

  // Only the highest-priority button of the cycle is considered at all.
  always_comb begin
    sel = SEL_NONE;
    if (btn_startstop)  sel = SEL_SS;
    else if (btn_clear) sel = SEL_CLR;
    else if (btn_lap)   sel = SEL_LAP;

    state_nxt = state_q;
    case (state_q)
      IDLE:  if (sel == SEL_SS) state_nxt = RUN;
      RUN:   if (sel == SEL_SS) state_nxt = PAUSE;
             else if (sel == SEL_LAP) state_nxt = LAP;
      LAP:   if (sel == SEL_SS) state_nxt = PAUSE;
             else if (sel == SEL_LAP) state_nxt = RUN;
      PAUSE: if (sel == SEL_SS) state_nxt = RUN;
             else if (sel == SEL_CLR) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    running_nxt = (state_nxt == RUN) || (state_nxt == LAP);
    lap_nxt     = (state_nxt == LAP);
    capture     = (state_q == RUN) && (sel == SEL_LAP);
    clr         = (state_q == PAUSE) && (sel == SEL_CLR);
  end

  // A tick on the capture cycle increments live while lap takes the old value.
  always_ff @(posedge boardCLK) begin
    if (reset || clr) begin
      live_q   <= '0;
      lap_q    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= tick_cs && (live_q == TIME_MAX);
      if (tick_cs) live_q <= bcd_inc(live_q);
      if (capture) lap_q  <= live_q;
    end
  end

  assign shown = lap_frozen ? lap_q : live_q;
  assign min_t = shown.m_t;
  assign min_o = shown.m_o;
  assign sec_t = shown.s_t;
  assign sec_o = shown.s_o;
  assign cs_t  = shown.c_t;
  assign cs_o  = shown.c_o;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Stopwatch bench: directed scenarios plus random buttons, all checked every
// cycle against a centisecond-integer model of the stopwatch.
module tb_stopwatch_ctrl;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int TMAX    = 359999;
  localparam logic [21:0] PRE = {3'd5, 4'd9, 3'd5, 4'd9, 4'd9, 4'd9};

  typedef enum {M_IDLE, M_RUN, M_LAP, M_PAUSE} m_mode_t;

  logic boardCLK = 1'b0;
  logic reset = 1'b1;
  logic btn_startstop = 1'b0, btn_lap = 1'b0, btn_clear = 1'b0;
  logic tick_cs, running, lap_frozen, overflow;
  logic [2:0] min_t, sec_t;
  logic [3:0] min_o, sec_o, cs_t, cs_o;

  int checks = 0;
  int errors = 0;

  m_mode_t m_mode = M_IDLE;
  int m_phase = 0;
  int m_time = 0;
  int m_lap = 0;
  bit m_tick = 1'b0;
  bit m_ovf = 1'b0;
  bit m_seen_rst = 1'b0;
  bit preload_req = 1'b0;

  stopwatch_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
    .boardCLK(boardCLK), .reset(reset),
    .btn_startstop(btn_startstop), .btn_lap(btn_lap), .btn_clear(btn_clear),
    .tick_cs(tick_cs), .running(running), .lap_frozen(lap_frozen), .overflow(overflow),
    .min_t(min_t), .min_o(min_o), .sec_t(sec_t), .sec_o(sec_o), .cs_t(cs_t), .cs_o(cs_o)
  );

  always #5 boardCLK = ~boardCLK;

  function automatic logic [21:0] digits_of(input int t);
    int m, s, c;
    m = t / 6000;
    s = (t / 100) % 60;
    c = t % 100;
    return {3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  // Model: time is an integer number of centiseconds; a tick lands one cycle
  // after every DIV-th running cycle and is added on the cycle it is visible.
  always @(posedge boardCLK) begin : model
    int nt, nph, nlap;
    bit ntk, nov;
    m_mode_t nm;
    if (preload_req) m_time = TMAX;
    if (reset) begin
      m_mode = M_IDLE; m_phase = 0; m_time = 0; m_lap = 0;
      m_tick = 1'b0; m_ovf = 1'b0; m_seen_rst = 1'b1;
    end else begin
      nt = m_time; nov = 1'b0;
      if (m_tick) begin
        nov = (m_time == TMAX);
        nt  = (m_time + 1) % (TMAX + 1);
      end
      ntk = 1'b0; nph = m_phase;
      if (m_mode == M_RUN || m_mode == M_LAP) begin
        nph = m_phase + 1;
        if (nph == DIV) begin nph = 0; ntk = 1'b1; end
      end
      nlap = m_lap; nm = m_mode;
      if (btn_startstop) begin
        nm = (m_mode == M_RUN || m_mode == M_LAP) ? M_PAUSE : M_RUN;
      end else if (btn_clear) begin
        if (m_mode == M_PAUSE) begin
          nm = M_IDLE; nt = 0; nlap = 0; nph = 0; ntk = 1'b0; nov = 1'b0;
        end
      end else if (btn_lap) begin
        if (m_mode == M_RUN) begin nm = M_LAP; nlap = m_time; end
        else if (m_mode == M_LAP) nm = M_RUN;
      end
      m_mode = nm; m_phase = nph; m_time = nt; m_lap = nlap; m_tick = ntk; m_ovf = nov;
    end
  end

  always @(negedge boardCLK) begin : compare
    logic [25:0] exp_v, act_v;
    if (m_seen_rst && !preload_req) begin
      exp_v = {m_tick, (m_mode == M_RUN) || (m_mode == M_LAP), m_mode == M_LAP, m_ovf,
               digits_of(m_mode == M_LAP ? m_lap : m_time)};
      act_v = {tick_cs, running, lap_frozen, overflow, min_t, min_o, sec_t, sec_o, cs_t, cs_o};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_compare t=%0t actual=%h required=%h", $time, act_v, exp_v);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge boardCLK); #1; end
  endtask

  task automatic press(input bit s, input bit c, input bit l);
    btn_startstop = s; btn_clear = c; btn_lap = l;
    cyc(1);
    btn_startstop = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
  endtask

  function automatic int disp();
    return ((int'(min_t) * 10 + int'(min_o)) * 100 + int'(sec_t) * 10 + int'(sec_o)) * 100
           + int'(cs_t) * 10 + int'(cs_o);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wait_disp(input string name, input int target, input int budget);
    int n = 0;
    while (disp() != target && n < budget) begin cyc(1); n++; end
    chk(name, disp(), target);
  endtask

  task automatic wait_tick(input int budget, output int n);
    n = 0;
    while (!tick_cs && n < budget) begin cyc(1); n++; end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int ticks, last, bad, gap;
    cyc(3);
    chk("rst_status", {28'd0, tick_cs, running, lap_frozen, overflow}, 0);
    chk("rst_disp", disp(), 0);
    reset = 1'b0;
    cyc(2);

    // 1: free run, 100 ticks exactly DIV apart
    press(1, 0, 0);
    ticks = 0; last = -1; bad = 0;
    for (int i = 1; i <= 1000; i++) begin
      cyc(1);
      if (tick_cs) begin
        if (last >= 0 && i - last != DIV) bad++;
        last = i; ticks++;
      end
    end
    chk("t1_ticks", ticks, 100);
    chk("t1_period", bad, 0);
    cyc(1);
    chk("t1_disp", disp(), 100);
    chk("t1_model_time", m_time, 100);
    chk("t1_running", running, 1);
    press(1, 0, 0);
    press(0, 1, 0);
    chk("t1_cleared", disp(), 0);

    // 2: pause holds display, resume finishes the partial period
    press(1, 0, 0);
    wait_disp("t2_reach37", 37, 1000);
    press(1, 0, 0);
    cyc(500);
    chk("t2_hold", disp(), 37);
    chk("t2_paused", running, 0);
    press(1, 0, 0);
    wait_tick(20, gap);
    chk("t2_resume_gap", gap, 8);

    // 3: lap freeze and release
    press(1, 0, 0);
    press(0, 1, 0);
    press(1, 0, 0);
    wait_disp("t3_reach25", 25, 1000);
    press(0, 0, 1);
    chk("t3_frozen", lap_frozen, 1);
    chk("t3_lap_disp", disp(), 25);
    cyc(200);
    chk("t3_still_frozen", disp(), 25);
    chk("t3_model_live", m_time, 45);
    press(0, 0, 1);
    chk("t3_unfrozen", lap_frozen, 0);
    chk("t3_live_disp", disp(), 45);

    // 5: priority and ignored buttons
    press(1, 0, 1);
    chk("t5_ss_lap_pause", {running, lap_frozen}, 0);
    press(1, 0, 0);
    press(0, 1, 0);
    chk("t5_clear_in_run", running, 1);
    press(1, 0, 0);
    press(0, 1, 0);
    chk("t5_clear_disp", disp(), 0);
    press(0, 0, 1);
    chk("t5_idle_lap", {running, lap_frozen}, 0);

    // 4: wrap at 59:59.99
    press(1, 0, 0);
    wait_tick(20, gap);
    cyc(1);
    preload_req = 1'b1;
    force dut.live_q = PRE;
    #1;
    release dut.live_q;
    cyc(1);
    preload_req = 1'b0;
    chk("t4_preload", disp(), 595999);
    wait_tick(20, gap);
    cyc(1);
    chk("t4_wrap_disp", disp(), 0);
    chk("t4_overflow", overflow, 1);
    chk("t4_running", running, 1);
    cyc(1);
    chk("t4_overflow_once", overflow, 0);

    // 6: reset coincident with a tick and a lap press
    wait_tick(20, gap);
    reset = 1'b1; btn_lap = 1'b1;
    cyc(1);
    reset = 1'b0; btn_lap = 1'b0;
    chk("t6_status", {28'd0, tick_cs, running, lap_frozen, overflow}, 0);
    chk("t6_disp", disp(), 0);

    // random buttons with occasional reset
    for (int i = 0; i < 5000; i++) begin
      btn_startstop = ($urandom_range(0, 19) == 0);
      btn_clear     = ($urandom_range(0, 9) == 0);
      btn_lap       = ($urandom_range(0, 9) == 0);
      reset         = ($urandom_range(0, 799) == 0);
      cyc(1);
    end
    btn_startstop = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0; reset = 1'b0;
    cyc(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
